// File: rtl/spi_byte_slave.sv
// SPI mode-0 byte responder, all SPI pins oversampled in the MasterCLK domain.
// Optional macro SPI_BYTE_SLAVE_OVERRUN_EN adds RxAck/Overrun/Underrun status.
module spi_byte_slave #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  IDLE_FILL   = 8'hFF
) (
  input  logic       MasterCLK,
  input  logic       ResetN,
  input  logic       SPI_CLK,
  input  logic       SPI_CS_N,
  input  logic       SPI_MOSI,
  output logic       SPI_MISO,
  output logic [7:0] RxData,
  output logic       RxValid,
  input  logic [7:0] TxData,
  input  logic       TxLoad,
  output logic       TxReady,
  output logic       Busy
`ifdef SPI_BYTE_SLAVE_OVERRUN_EN
  ,
  input  logic       RxAck,
  output logic       Overrun,
  output logic       Underrun
`endif
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] clk_sync, cs_sync, mosi_sync;
  logic       clk_prev, cs_prev;
  logic       sclk_s, cs_s, mosi_s;
  logic       sclk_rise, sclk_fall, cs_fall, cs_rise;

  logic [7:0] rx_shift, tx_shift, tx_buf, fill_byte;
  logic [2:0] bit_cnt;
  logic       byte_done, tx_full;
  logic       start, stop, shift_in, shift_out, consume, rx_fire, load_ok;

  // Synchronisers preset to idle pin levels so reset never fabricates an edge on SCLK.
  always_ff @(posedge MasterCLK or negedge ResetN) begin
    if (!ResetN) begin
      clk_sync  <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      clk_prev  <= 1'b0;
      cs_prev   <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], SPI_CLK};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], SPI_CS_N};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], SPI_MOSI};
      clk_prev  <= clk_sync[SYNC_STAGES-1];
      cs_prev   <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = clk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~clk_prev;
  assign sclk_fall = ~sclk_s & clk_prev;
  assign cs_fall   = ~cs_s & cs_prev;
  assign cs_rise   = cs_s & ~cs_prev;

  always_ff @(posedge MasterCLK or negedge ResetN) begin
    if (!ResetN) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    stop       = 1'b0;
    shift_in   = 1'b0;
    shift_out  = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          start      = 1'b1;
          state_next = ACTIVE;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          stop       = 1'b1;
          state_next = IDLE;
        end else begin
          shift_in  = sclk_rise;
          shift_out = sclk_fall;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign consume   = start | (shift_out & byte_done);
  assign fill_byte = tx_full ? tx_buf : IDLE_FILL;
  assign rx_fire   = shift_in & (bit_cnt == 3'd7);
  assign load_ok   = TxLoad & ~tx_full;

  always_ff @(posedge MasterCLK or negedge ResetN) begin
    if (!ResetN) begin
      rx_shift  <= '0;
      tx_shift  <= '0;
      bit_cnt   <= '0;
      byte_done <= 1'b0;
      RxData    <= '0;
      RxValid   <= 1'b0;
    end else begin
      RxValid <= 1'b0;
      if (start) begin
        bit_cnt   <= '0;
        byte_done <= 1'b0;
        tx_shift  <= fill_byte;
      end else if (stop) begin
        bit_cnt   <= '0;
        byte_done <= 1'b0;
      end else if (shift_in) begin
        rx_shift <= {rx_shift[6:0], mosi_s};
        bit_cnt  <= bit_cnt + 3'd1;
        if (rx_fire) begin
          RxData    <= {rx_shift[6:0], mosi_s};
          RxValid   <= 1'b1;
          byte_done <= 1'b1;
        end
      end else if (shift_out) begin
        if (byte_done) begin
          tx_shift  <= fill_byte;
          byte_done <= 1'b0;
        end else begin
          tx_shift <= {tx_shift[6:0], 1'b1};
        end
      end
    end
  end

  // A load is only accepted while empty, so it never collides with a consume of a full buffer;
  // a same-cycle consume of an empty buffer sends the fill byte and keeps the new load.
  always_ff @(posedge MasterCLK or negedge ResetN) begin
    if (!ResetN) begin
      tx_buf  <= '0;
      tx_full <= 1'b0;
    end else if (load_ok) begin
      tx_buf  <= TxData;
      tx_full <= 1'b1;
    end else if (consume) begin
      tx_full <= 1'b0;
    end
  end

  assign TxReady  = ~tx_full;
  assign Busy     = (state == ACTIVE);
  assign SPI_MISO = (state == ACTIVE) ? tx_shift[7] : 1'b1;

`ifdef SPI_BYTE_SLAVE_OVERRUN_EN
  logic rx_pending;

  always_ff @(posedge MasterCLK or negedge ResetN) begin
    if (!ResetN) begin
      rx_pending <= 1'b0;
      Overrun    <= 1'b0;
      Underrun   <= 1'b0;
    end else begin
      rx_pending <= rx_fire | (rx_pending & ~RxAck);
      if (RxAck) begin
        Overrun  <= 1'b0;
        Underrun <= 1'b0;
      end
      if (rx_fire && rx_pending && !RxAck) Overrun <= 1'b1;
      if (shift_out && byte_done && !tx_full) Underrun <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_spi_byte_slave.sv
// Self-checking bench for spi_byte_slave: byte-level master model with a TX-buffer reference.
module tb_spi_byte_slave;
  localparam int unsigned SYNC = 2;

  logic       MasterCLK = 1'b0;
  logic       ResetN    = 1'b0;
  logic       SPI_CLK   = 1'b0;
  logic       SPI_CS_N  = 1'b1;
  logic       SPI_MOSI  = 1'b0;
  logic       SPI_MISO;
  logic [7:0] RxData;
  logic       RxValid;
  logic [7:0] TxData    = 8'h00;
  logic       TxLoad    = 1'b0;
  logic       TxReady;
  logic       Busy;
`ifdef SPI_BYTE_SLAVE_OVERRUN_EN
  logic       RxAck = 1'b0;
  logic       Overrun, Underrun;
`endif

  spi_byte_slave #(.SYNC_STAGES(SYNC), .IDLE_FILL(8'hFF)) dut (
    .MasterCLK(MasterCLK), .ResetN(ResetN), .SPI_CLK(SPI_CLK), .SPI_CS_N(SPI_CS_N),
    .SPI_MOSI(SPI_MOSI), .SPI_MISO(SPI_MISO), .RxData(RxData), .RxValid(RxValid),
    .TxData(TxData), .TxLoad(TxLoad), .TxReady(TxReady), .Busy(Busy)
`ifdef SPI_BYTE_SLAVE_OVERRUN_EN
    , .RxAck(RxAck), .Overrun(Overrun), .Underrun(Underrun)
`endif
  );

  always #5 MasterCLK = ~MasterCLK;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc    = 0;
  always @(posedge MasterCLK) cyc <= cyc + 1;

  // Received-byte monitor, sampled on the inactive edge.
  logic [7:0]  rx_q[$];
  int unsigned rx_cyc_q[$];
  always @(negedge MasterCLK) begin
    if (ResetN && RxValid === 1'b1) begin
      rx_q.push_back(RxData);
      rx_cyc_q.push_back(cyc);
    end
  end

  // Reference: single-entry TX buffer; each byte slot takes the buffer or the idle fill.
  logic       m_full = 1'b0;
  logic [7:0] m_buf  = 8'h00;
  logic [7:0] m_rx   = 8'h00;

  logic [7:0]  mosi_arr[8];
  logic [7:0]  got_miso[8];
  logic [7:0]  exp_miso[8];
  int unsigned got_rise[8];

  task automatic wait_clk(input int n);
    repeat (n) @(negedge MasterCLK);
  endtask

  task automatic tx_load(input logic [7:0] d);
    @(negedge MasterCLK);
    TxData = d;
    TxLoad = 1'b1;
    @(negedge MasterCLK);
    TxLoad = 1'b0;
    if (!m_full) begin
      m_full = 1'b1;
      m_buf  = d;
    end
  endtask

  task automatic model_take(output logic [7:0] b);
    b      = m_full ? m_buf : 8'hFF;
    m_full = 1'b0;
  endtask

  // Expected MISO for n complete bytes; the byte boundary after the last byte also drains the buffer.
  task automatic predict(input int n);
    logic [7:0] dummy;
    for (int b = 0; b < n; b++) model_take(exp_miso[b]);
    model_take(dummy);
  endtask

  task automatic cs_low();
    @(negedge MasterCLK);
    SPI_CS_N = 1'b0;
    wait_clk(4);
  endtask

  task automatic cs_high();
    wait_clk(4);
    SPI_CS_N = 1'b1;
    wait_clk(8);
  endtask

  // Master side at SCLK = MasterCLK/16: set MOSI, rise (sample MISO), fall.
  task automatic xfer_bits(input logic [7:0] mosi, input int nbits,
                           output logic [7:0] miso, output int unsigned rise_cyc);
    miso     = 8'hFF;
    rise_cyc = 0;
    for (int i = 0; i < nbits; i++) begin
      SPI_MOSI = mosi[7-i];
      wait_clk(8);
      SPI_CLK  = 1'b1;
      rise_cyc = cyc;
      miso     = {miso[6:0], SPI_MISO};
      wait_clk(8);
      SPI_CLK  = 1'b0;
    end
  endtask

  task automatic frame(input int n);
    rx_q.delete();
    rx_cyc_q.delete();
    cs_low();
    for (int b = 0; b < n; b++) xfer_bits(mosi_arr[b], 8, got_miso[b], got_rise[b]);
    cs_high();
  endtask

  task automatic test_reset();
    ResetN = 1'b0;
    wait_clk(3);
    ResetN = 1'b1;
    wait_clk(5);
    checks++; if (SPI_MISO !== 1'b1) begin errors++; $display("FAIL reset_miso got %b exp 1", SPI_MISO); end
    checks++; if (TxReady !== 1'b1) begin errors++; $display("FAIL reset_txready got %b exp 1", TxReady); end
    checks++; if (RxValid !== 1'b0) begin errors++; $display("FAIL reset_rxvalid got %b exp 0", RxValid); end
    checks++; if (RxData !== 8'h00) begin errors++; $display("FAIL reset_rxdata got %h exp 00", RxData); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", Busy); end
  endtask

  task automatic test_single_byte();
    tx_load(8'hA5);
    wait_clk(1);
    checks++; if (TxReady !== 1'b0) begin errors++; $display("FAIL single_txready_loaded got %b exp 0", TxReady); end
    mosi_arr[0] = 8'h3C;
    predict(1);
    rx_q.delete();
    rx_cyc_q.delete();
    cs_low();
    checks++; if (TxReady !== 1'b1) begin errors++; $display("FAIL single_txready_after_cs got %b exp 1", TxReady); end
    checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", Busy); end
    xfer_bits(mosi_arr[0], 8, got_miso[0], got_rise[0]);
    cs_high();
    m_rx = 8'h3C;
    checks++; if (got_miso[0] !== exp_miso[0]) begin errors++; $display("FAIL single_miso got %h exp %h", got_miso[0], exp_miso[0]); end
    checks++; if (rx_q.size() != 1) begin errors++; $display("FAIL single_pulses got %0d exp 1", rx_q.size()); end
    else begin
      checks++; if (rx_q[0] !== 8'h3C) begin errors++; $display("FAIL single_rx got %h exp 3c", rx_q[0]); end
      checks++;
      if (rx_cyc_q[0] - got_rise[0] != SYNC + 1) begin
        errors++; $display("FAIL single_latency got %0d exp %0d", rx_cyc_q[0] - got_rise[0], SYNC + 1);
      end
    end
    checks++; if (RxData !== 8'h3C) begin errors++; $display("FAIL single_rxdata got %h exp 3c", RxData); end
    checks++; if (Busy !== 1'b0 || SPI_MISO !== 1'b1) begin errors++; $display("FAIL single_idle got busy=%b miso=%b exp 0/1", Busy, SPI_MISO); end
  endtask

  task automatic test_back_to_back();
    tx_load(8'h5A);
    mosi_arr[0] = 8'h01; mosi_arr[1] = 8'h80; mosi_arr[2] = 8'hFF;
    predict(3);
    frame(3);
    m_rx = 8'hFF;
    checks++; if (rx_q.size() != 3) begin errors++; $display("FAIL b2b_pulses got %0d exp 3", rx_q.size()); end
    for (int b = 0; b < 3; b++) begin
      checks++;
      if (got_miso[b] !== exp_miso[b]) begin errors++; $display("FAIL b2b_miso[%0d] got %h exp %h", b, got_miso[b], exp_miso[b]); end
      if (b < rx_q.size()) begin
        checks++;
        if (rx_q[b] !== mosi_arr[b]) begin errors++; $display("FAIL b2b_rx[%0d] got %h exp %h", b, rx_q[b], mosi_arr[b]); end
      end
    end
  endtask

  task automatic test_partial_abort();
    logic [7:0]  junk;
    int unsigned jr;
    logic [7:0]  first;
    rx_q.delete();
    model_take(first);
    cs_low();
    xfer_bits(8'hC3, 5, junk, jr);
    cs_high();
    checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL abort_pulses got %0d exp 0", rx_q.size()); end
    checks++; if (RxData !== m_rx) begin errors++; $display("FAIL abort_rxdata got %h exp %h", RxData, m_rx); end
    tx_load(8'h6E);
    mosi_arr[0] = 8'h42;
    predict(1);
    frame(1);
    m_rx = 8'h42;
    checks++; if (got_miso[0] !== exp_miso[0]) begin errors++; $display("FAIL abort_next_miso got %h exp %h", got_miso[0], exp_miso[0]); end
    checks++; if (rx_q.size() != 1 || RxData !== 8'h42) begin errors++; $display("FAIL abort_next_rx got %0d/%h exp 1/42", rx_q.size(), RxData); end
  endtask

  task automatic test_load_drop();
    tx_load(8'h11);
    tx_load(8'h22);
    checks++; if (TxReady !== 1'b0) begin errors++; $display("FAIL drop_txready got %b exp 0", TxReady); end
    mosi_arr[0] = 8'h0F;
    predict(1);
    frame(1);
    m_rx = 8'h0F;
    checks++; if (got_miso[0] !== exp_miso[0]) begin errors++; $display("FAIL drop_miso got %h exp %h", got_miso[0], exp_miso[0]); end
    checks++; if (TxReady !== 1'b1) begin errors++; $display("FAIL drop_drained got %b exp 1", TxReady); end
  endtask

  task automatic test_reset_mid_byte();
    logic [7:0]  junk;
    int unsigned jr;
    logic [7:0]  first;
    model_take(first);
    cs_low();
    tx_load(8'h77);
    xfer_bits(8'hE4, 4, junk, jr);
    @(negedge MasterCLK);
    ResetN = 1'b0;
    #1;
    m_full = 1'b0;
    m_rx   = 8'h00;
    checks++; if (RxData !== 8'h00 || RxValid !== 1'b0) begin errors++; $display("FAIL midrst_rx got %h/%b exp 00/0", RxData, RxValid); end
    checks++; if (TxReady !== 1'b1 || SPI_MISO !== 1'b1 || Busy !== 1'b0) begin
      errors++; $display("FAIL midrst_ctl got rdy=%b miso=%b busy=%b exp 1/1/0", TxReady, SPI_MISO, Busy);
    end
    SPI_CS_N = 1'b1;
    wait_clk(3);
    ResetN = 1'b1;
    wait_clk(6);
    mosi_arr[0] = 8'h99;
    predict(1);
    frame(1);
    m_rx = 8'h99;
    checks++; if (got_miso[0] !== exp_miso[0]) begin errors++; $display("FAIL midrst_miso got %h exp %h", got_miso[0], exp_miso[0]); end
    checks++; if (rx_q.size() != 1 || RxData !== 8'h99) begin errors++; $display("FAIL midrst_rx99 got %0d/%h exp 1/99", rx_q.size(), RxData); end
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 8; it++) begin
      int unsigned loads = $urandom_range(0, 2);
      for (int l = 0; l < loads; l++) tx_load(8'($urandom));
      wait_clk(1);
      checks++; if (TxReady !== !m_full) begin errors++; $display("FAIL rnd%0d_txready got %b exp %b", it, TxReady, !m_full); end
      n = $urandom_range(1, 3);
      for (int b = 0; b < n; b++) mosi_arr[b] = 8'($urandom);
      predict(n);
      frame(n);
      m_rx = mosi_arr[n-1];
      checks++; if (rx_q.size() != n) begin errors++; $display("FAIL rnd%0d_pulses got %0d exp %0d", it, rx_q.size(), n); end
      for (int b = 0; b < n; b++) begin
        checks++;
        if (got_miso[b] !== exp_miso[b]) begin errors++; $display("FAIL rnd%0d_miso[%0d] got %h exp %h", it, b, got_miso[b], exp_miso[b]); end
        if (b < rx_q.size()) begin
          checks++;
          if (rx_q[b] !== mosi_arr[b]) begin errors++; $display("FAIL rnd%0d_rx[%0d] got %h exp %h", it, b, rx_q[b], mosi_arr[b]); end
        end
      end
      checks++; if (RxData !== m_rx) begin errors++; $display("FAIL rnd%0d_rxdata got %h exp %h", it, RxData, m_rx); end
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_partial_abort();
    test_load_drop();
    test_reset_mid_byte();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_byte_slave.md
Name: spi_byte_slave

Overview:
- SPI mode-0 responder (target side) for the SD/SPI peripheral; the counterpart of the team's SPI master byte engine.
- Lets a bus-side model or an on-chip SPI target exchange bytes with that master.
- All SPI pins are oversampled in the MasterCLK domain.
- Full-duplex, MSB-first, one byte per 8 SCLK cycles. Received byte is delivered with a one-cycle strobe; transmit byte comes from a single-entry buffer with a ready/load handshake.

Parameters:
- SYNC_STAGES, 2, synchroniser flops on SPI_CLK, SPI_CS_N and SPI_MOSI (minimum 2).
- IDLE_FILL, 8'hFF, byte shifted out when the TX buffer is empty at a byte boundary.

Ports:
- MasterCLK  input  1  system clock; must be at least 8x the SCLK frequency.
- ResetN  input  1  asynchronous active-low reset.
- SPI_CLK  input  1  SCLK from master; mode 0 (idle low, sample rising, shift falling).
- SPI_CS_N  input  1  chip select, active low.
- SPI_MOSI  input  1  serial data from master.
- SPI_MISO  output  1  serial data to master; driven 1 while deselected.
- RxData  output  8  last complete received byte.
- RxValid  output  1  one-cycle strobe when RxData updates.
- TxData  input  8  next byte to transmit.
- TxLoad  input  1  write strobe for TxData.
- TxReady  output  1  TX buffer empty; TxLoad accepted only while this is 1.
- Busy  output  1  CS asserted (synchronised).

Behaviour:
- Reset (async, ResetN=0):
  - RxData=0, RxValid=0, TxReady=1, SPI_MISO=1, Busy=0.
  - Shift registers and bit counter cleared; synchronisers preset to the idle levels (CS_N=1, CLK=0).
- Synchronisation: all three SPI inputs pass SYNC_STAGES flops. Edge detection compares the last two synchronised SCLK/CS_N samples.
- States:
  - IDLE: CS_N high. Busy=0, SPI_MISO=1, bit counter held at 0.
  - IDLE -> ACTIVE on synchronised CS_N falling edge:
    - bitCnt=0.
    - txShift loads the TX buffer if full (TxReady goes 1 next cycle), else IDLE_FILL.
    - SPI_MISO=txShift[7] from the next cycle.
  - ACTIVE, synchronised SCLK rising edge:
    - rxShift <= {rxShift[6:0], MOSI}; bitCnt++ (3-bit, wraps 7->0).
    - When bitCnt was 7: RxData <= {rxShift[6:0], MOSI}, RxValid=1 for exactly one cycle, and byteDone is set.
  - ACTIVE, synchronised SCLK falling edge:
    - If byteDone: reload txShift from the TX buffer (or IDLE_FILL) and clear byteDone.
    - Otherwise txShift <<= 1, LSB filled with 1.
  - ACTIVE -> IDLE on synchronised CS_N rising edge, in any bit position:
    - Partial byte discarded, no RxValid, bitCnt=0, byteDone cleared.
    - A TX buffer not yet consumed is retained.
- Latency: RxValid rises SYNC_STAGES+1 MasterCLK cycles after the 8th SCLK rising edge at the pin.
- TX handshake:
  - TxLoad while TxReady=1 captures TxData and drops TxReady next cycle.
  - TxLoad while TxReady=0 is ignored; the buffer is unchanged.
  - Consume and TxLoad in the same cycle: the consume sees the pre-cycle buffer state, so an empty buffer sends IDLE_FILL and the new byte is stored for the following byte.
- Back-to-back bytes need no gap; CS may stay low across any number of bytes.
- SCLK edges while CS_N is high are ignored.
- Reset mid-byte: immediate return to the reset state; the next transfer requires a fresh CS_N falling edge.

Optional Feature:
- Macro: SPI_BYTE_SLAVE_OVERRUN_EN.
- Enabled: adds output Overrun (1 bit, reset 0) and two latched status bits.
  - Overrun is set when RxValid fires while the previous byte is unacknowledged.
  - Acknowledgement is a new input RxAck pulse; RxAck also clears Overrun.
  - Adds a sticky Underrun flag, set when IDLE_FILL is substituted inside ACTIVE and cleared by RxAck.
- Disabled: no RxAck, Overrun or Underrun ports; RxData is simply overwritten.

Test Plan:
- After reset, no stimulus -> SPI_MISO=1, TxReady=1, RxValid=0, RxData=8'h00.
- TxLoad with TxData=8'hA5, then CS low, master sends 8'h3C at SCLK=MasterCLK/16 -> master receives 8'hA5, RxData=8'h3C with a single RxValid pulse, TxReady=1 after the CS fall.
- Three back-to-back bytes under continuous CS, MOSI 8'h01,8'h80,8'hFF, TX loaded only before byte 1 with 8'h5A -> MISO bytes 8'h5A,8'hFF,8'hFF; three RxValid pulses with matching data.
- CS released after 5 SCLK cycles of 8'hC3 -> no RxValid, RxData unchanged; the next full byte 8'h42 is received correctly.
- TxLoad of 8'h11 then a second TxLoad of 8'h22 before any transfer -> 8'h11 transmitted, 8'h22 dropped.
- ResetN pulsed low mid-byte -> all outputs at reset values within the same cycle; the next CS transfer of 8'h99 is received cleanly.
